// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// A winner's operands are latched at capture, held on the ALU ports through
// ISSUE and EXEC, and the ALU output is registered into res/res_flags.
// Fixed four-cycle transaction, one operation in flight, no queueing.
//
// Build option:
//   ALU_ARBITER_FIXED_PRIO_EN  defined   -> requester 0 always wins contention
//                              undefined -> round-robin (default)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; any req sampled here captures the winner's operands
// ISSUE | gnt pulse to winner; operands on the ALU ports
// EXEC  | ALU settles; result and flags registered on leaving this state
// DONE  | done pulse to winner; res/res_flags valid

module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 8,
    parameter int FLW   = 5
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   op0,
    input  logic [OPW-1:0]   op1,

    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res,
    output logic [FLW-1:0]   res_flags,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_c,
    input  logic [FLW-1:0]   alu_flags,

    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;

    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [OPW-1:0]   opc_q, opc_d;
    logic             winner_q, winner_d;   // 1 = requester 1 owns the transaction

    logic [WIDTH-1:0] res_q, res_d;
    logic [FLW-1:0]   flags_q, flags_d;

    logic             any_req;
    logic             capture;
    logic             pick1;                // arbitration result: requester 1 wins

    // Request qualification: only IDLE listens; requests elsewhere are ignored
    always_comb begin
        any_req = req0 | req1;
        capture = (state_q == S_IDLE) & any_req;
    end

`ifdef ALU_ARBITER_FIXED_PRIO_EN

    // Fixed priority: requester 1 wins only when requester 0 is silent
    always_comb begin
        pick1 = req1 & ~req0;
    end

`else

    logic last_q, last_d;                   // 1 = requester 1 was granted last

    // Round-robin: on contention grant whoever was not granted last
    always_comb begin
        pick1 = req1 & (~req0 | ~last_q);
    end

    // Last-grant tracking, touched only when a grant is actually made
    always_comb begin
        last_d = last_q;
        if (capture) begin
            last_d = pick1;
        end
    end

    // Last-grant register; reset value makes requester 0 win first contention
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: fixed IDLE -> ISSUE -> EXEC -> DONE -> IDLE walk
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: pulses are decoded from state plus the recorded winner
    always_comb begin
        busy  = (state_q != S_IDLE);
        gnt0  = (state_q == S_ISSUE) & ~winner_q;
        gnt1  = (state_q == S_ISSUE) &  winner_q;
        done0 = (state_q == S_DONE)  & ~winner_q;
        done1 = (state_q == S_DONE)  &  winner_q;
    end

    // Operand capture: winner's a/b/op are frozen so requesters may move on after gnt
    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        opc_d    = opc_q;
        winner_d = winner_q;
        if (capture) begin
            winner_d = pick1;
            opa_d    = pick1 ? a1  : a0;
            opb_d    = pick1 ? b1  : b0;
            opc_d    = pick1 ? op1 : op0;
        end
    end

    // Operand and winner registers
    always_ff @(posedge clk) begin
        if (reset) begin
            opa_q    <= '0;
            opb_q    <= '0;
            opc_q    <= '0;
            winner_q <= 1'b0;
        end else begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            opc_q    <= opc_d;
            winner_q <= winner_d;
        end
    end

    // Result capture on the EXEC -> DONE edge; held until the next capture
    always_comb begin
        res_d   = res_q;
        flags_d = flags_q;
        if (state_q == S_EXEC) begin
            res_d   = alu_c;
            flags_d = alu_flags;
        end
    end

    // Result and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    // Port drive: the ALU sees only the frozen operand registers
    always_comb begin
        alu_a     = opa_q;
        alu_b     = opb_q;
        alu_op    = opc_q;
        res       = res_q;
        res_flags = flags_q;
    end

    // Pulses to the two requesters are mutually exclusive by construction
    a_gnt_excl: assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));
    a_done_excl: assert property (@(posedge clk) disable iff (reset) !(done0 && done1));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model feeds expected
// grants/completions into queues; a monitor on the falling edge pops and
// compares whenever the DUT pulses gnt or done. ALU stub: c = a ^ b,
// flags = op[4:0]. Directed scenarios first, then randomized traffic.

module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int OPW   = 8;
    localparam int FLW   = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [WIDTH-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [OPW-1:0]   op0 = '0, op1 = '0;
    logic             gnt0, gnt1, done0, done1, busy;
    logic [WIDTH-1:0] res, alu_a, alu_b, alu_c;
    logic [FLW-1:0]   res_flags, alu_flags;
    logic [OPW-1:0]   alu_op;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .FLW(FLW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .op0(op0), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .res_flags(res_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .busy(busy)
    );

    assign alu_c     = alu_a ^ alu_b;
    assign alu_flags = alu_op[4:0];

    always #5 clk = ~clk;

    int cyc = 0;                       // number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               who;
        int               cyc;
        logic [WIDTH-1:0] res;
        logic [FLW-1:0]   fl;
    } exp_t;

    exp_t gq[$];
    exp_t dq[$];
    int   glog_who[$], glog_cyc[$], dlog_who[$], dlog_cyc[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int next_free  = 0;                // earliest edge at which a new request can be taken
    int busy_from  = 1;
    int busy_until = 0;
    int last_m     = 1;                // requester granted last (1 favours 0 next)
    int gedge0 = -1, gedge1 = -1;

    bit               mon_en = 1'b0;
    bit               auto_rel = 1'b0;
    bit               prev_reset = 1'b0;
    logic [WIDTH-1:0] held_res = '0;
    logic [FLW-1:0]   held_fl = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Predict what happens at the coming edge from the inputs about to be sampled
    task automatic model_edge();
        int e;
        e = cyc + 1;
        if (reset) begin
            for (int i = gq.size() - 1; i >= 0; i--) if (gq[i].cyc >= e) gq.delete(i);
            for (int i = dq.size() - 1; i >= 0; i--) if (dq[i].cyc >= e) dq.delete(i);
            next_free = e + 1;
            if (busy_until > e - 1) busy_until = e - 1;
            last_m = 1;
        end else if (e >= next_free && (req0 || req1)) begin
            int   w;
            exp_t x;
            if (req0 && req1) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
                w = 0;
`else
                w = (last_m == 1) ? 0 : 1;
`endif
            end else begin
                w = req0 ? 0 : 1;
            end
            last_m = w;
            x.who = w;
            x.cyc = e;
            x.res = (w == 1) ? (a1 ^ b1) : (a0 ^ b0);
            x.fl  = (w == 1) ? op1[4:0] : op0[4:0];
            gq.push_back(x);
            x.cyc = e + 2;
            dq.push_back(x);
            next_free  = e + 4;
            busy_from  = e;
            busy_until = e + 2;
            if (w == 0) gedge0 = e; else gedge1 = e;
        end
    endtask

    // One clock: model the edge, advance, then let granted requesters let go
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        if (auto_rel) begin
            if (gedge0 == cyc) begin
                req0 = 1'b0;
                if ($urandom_range(0, 1) == 1) a0 = WIDTH'($urandom);
            end
            if (gedge1 == cyc) begin
                req1 = 1'b0;
                if ($urandom_range(0, 1) == 1) b1 = WIDTH'($urandom);
            end
        end
    endtask

    task automatic clear_logs();
        glog_who.delete(); glog_cyc.delete();
        dlog_who.delete(); dlog_cyc.delete();
    endtask

    // Monitor: compare every DUT pulse against the head of the expectation queues
    always @(negedge clk) begin
        exp_t x;
        if (mon_en) begin
            if (prev_reset) begin
                held_res = '0;
                held_fl  = '0;
            end
            chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
            chk("done_exclusive", 32'(done0 & done1), 32'd0);
            chk("busy", 32'(busy), 32'((cyc >= busy_from) && (cyc <= busy_until)));
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                chk("gnt_missing_cycle", 32'(cyc), 32'(gq[0].cyc));
                void'(gq.pop_front());
            end
            while (dq.size() > 0 && dq[0].cyc < cyc) begin
                chk("done_missing_cycle", 32'(cyc), 32'(dq[0].cyc));
                void'(dq.pop_front());
            end
            if (gnt0 || gnt1) begin
                glog_who.push_back(gnt1 ? 1 : 0);
                glog_cyc.push_back(cyc);
                chk("gnt_expected", 32'(gq.size() > 0), 32'd1);
                if (gq.size() > 0) begin
                    x = gq.pop_front();
                    chk("gnt_who", 32'(gnt1), 32'(x.who));
                    chk("gnt_cycle", 32'(cyc), 32'(x.cyc));
                end
            end
            if (done0 || done1) begin
                dlog_who.push_back(done1 ? 1 : 0);
                dlog_cyc.push_back(cyc);
                chk("done_expected", 32'(dq.size() > 0), 32'd1);
                if (dq.size() > 0) begin
                    x = dq.pop_front();
                    chk("done_who", 32'(done1), 32'(x.who));
                    chk("done_cycle", 32'(cyc), 32'(x.cyc));
                    chk("done_res", 32'(res), 32'(x.res));
                    chk("done_flags", 32'(res_flags), 32'(x.fl));
                    held_res = x.res;
                    held_fl  = x.fl;
                end
            end
            chk("res_hold", 32'(res), 32'(held_res));
            chk("flags_hold", 32'(res_flags), 32'(held_fl));
        end
        prev_reset = reset;
    end

    int e0;
    int exp_w[3];

    initial begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        exp_w[0] = 0; exp_w[1] = 0; exp_w[2] = 0;
`else
        exp_w[0] = 0; exp_w[1] = 1; exp_w[2] = 0;
`endif
        #1;
        tick();
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_res", 32'(res), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_gnt", 32'({gnt0, gnt1, done0, done1}), 32'd0);

        // single request from requester 0
        clear_logs();
        auto_rel = 1'b1;
        req0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0F0F; op0 = 8'h03;
        e0 = cyc + 1;
        repeat (6) tick();
        chk("single_gnt_count", 32'(glog_who.size()), 32'd1);
        chk("single_gnt_who", 32'(glog_who[0]), 32'd0);
        chk("single_gnt_cycle", 32'(glog_cyc[0]), 32'(e0));
        chk("single_done_count", 32'(dlog_who.size()), 32'd1);
        chk("single_done_cycle", 32'(dlog_cyc[0]), 32'(e0 + 2));
        chk("single_res", 32'(res), 32'h0FF0);
        chk("single_flags", 32'(res_flags), 32'h03);

        // sustained contention over three transactions
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_logs();
        auto_rel = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a1 = 16'h1357; b1 = 16'h2468; op1 = 8'h1C;
        e0 = cyc + 1;
        repeat (12) tick();
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();
        chk("contend_gnt_count", 32'(glog_who.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("contend_gnt_order", 32'(glog_who[i]), 32'(exp_w[i]));
        chk("contend_first_cycle", 32'(glog_cyc[0]), 32'(e0));
        chk("contend_done_count", 32'(dlog_cyc.size()), 32'd3);
        chk("contend_done_gap1", 32'(dlog_cyc[1] - dlog_cyc[0]), 32'd4);
        chk("contend_done_gap2", 32'(dlog_cyc[2] - dlog_cyc[1]), 32'd4);

        // operands change right after the grant
        clear_logs();
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h00F0; op0 = 8'h15;
        tick();
        a0 = 16'hFFFF; b0 = 16'h0000; op0 = 8'hEA; req0 = 1'b0;
        repeat (4) tick();
        chk("opchg_res", 32'(res), 32'h12C4);
        chk("opchg_flags", 32'(res_flags), 32'h15);

        // reset while in EXEC, then contention
        clear_logs();
        req0 = 1'b1; a0 = 16'hA5A5; b0 = 16'h0001;
        tick();
        req0 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_res", 32'(res), 32'd0);
        chk("midrst_flags", 32'(res_flags), 32'd0);
        repeat (3) tick();
        chk("midrst_no_done", 32'(dlog_cyc.size()), 32'd0);
        req0 = 1'b1; req1 = 1'b1;
        tick();
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();
        chk("midrst_gnt_count", 32'(glog_who.size()), 32'd2);
        chk("midrst_contend_who", 32'(glog_who[1]), 32'd0);

        // late request from requester 1 during a requester-0 transaction
        clear_logs();
        auto_rel = 1'b1;
        req0 = 1'b1; a0 = 16'h0F00;
        tick();
        req1 = 1'b1; a1 = 16'h7777;
        repeat (8) tick();
        chk("late_gnt_count", 32'(glog_who.size()), 32'd2);
        chk("late_second_who", 32'(glog_who[1]), 32'd1);
        chk("late_gap", 32'(glog_cyc[1] - glog_cyc[0]), 32'd4);

        // randomized traffic with occasional resets
        repeat (3000) begin
            reset = ($urandom_range(0, 149) == 0);
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1;
                a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); op0 = OPW'($urandom);
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1;
                a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); op1 = OPW'($urandom);
            end
            tick();
        end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (6) tick();
        chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
        chk("done_queue_drained", 32'(dq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters SHALL be WIDTH, default 16, operand/result width; OPW, default 8, opcode width; FLW, default 5, flag width.
REQ-002 The clock port SHALL be clk, input, 1 bit; one clock, all state updates on the rising edge.
REQ-003 The reset port SHALL be reset, input, 1 bit; synchronous, active-high.
REQ-004 req0/req1 SHALL be input, 1 bit each; requester n requests an ALU operation.
REQ-005 a0/a1 and b0/b1 SHALL be input, WIDTH each; operands A and B of requester n.
REQ-006 op0/op1 SHALL be input, OPW each; opcode of requester n.
REQ-007 gnt0/gnt1 SHALL be output, 1 bit each; one-cycle pulse when requester n's operands are captured.
REQ-008 done0/done1 SHALL be output, 1 bit each; one-cycle pulse when requester n's result is valid.
REQ-009 res SHALL be output, WIDTH; res_flags SHALL be output, FLW; last completed result and flags.
REQ-010 alu_a/alu_b SHALL be output, WIDTH; alu_op SHALL be output, OPW; drive the shared combinational ALU.
REQ-011 alu_c SHALL be input, WIDTH; alu_flags SHALL be input, FLW; ALU result and flags.
REQ-012 busy SHALL be output, 1 bit; high in every state except IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, ISSUE, EXEC, DONE; IDLE->ISSUE on any req sampled high, ISSUE->EXEC, EXEC->DONE, DONE->IDLE unconditionally.
REQ-014 In IDLE with a request pending, the block SHALL select a winner, latch that requester's a/b/op into operand registers, and pulse the matching gnt on the following cycle (ISSUE).
REQ-015 alu_a/alu_b/alu_op SHALL be driven from the operand registers, stable throughout ISSUE and EXEC; requesters MAY change operands after gnt.
REQ-016 At the EXEC->DONE edge, the block SHALL register alu_c into res and alu_flags into res_flags.
REQ-017 In DONE, the block SHALL assert the winner's done for exactly one cycle; res/res_flags SHALL hold until the next capture.
REQ-018 Latency SHALL be fixed: req sampled at edge k -> gnt high cycle k+1 -> done high cycle k+3; throughput one operation per 4 cycles.
REQ-019 Requesters SHALL hold req high until gnt; a req still high in IDLE after DONE SHALL start a new transaction.
REQ-020 Arbitration SHALL be round-robin: if both req are high, grant the requester not granted last; a single requester always wins.
REQ-021 The last-grant register SHALL update only on a grant; its reset value SHALL favour requester 0.
REQ-022 gnt0/gnt1 SHALL never both be high; done0/done1 SHALL never both be high.
REQ-023 A req asserted during ISSUE/EXEC/DONE SHALL be ignored until IDLE; no queueing.
REQ-024 The block SHALL not modify A/B/op width or interpret opcodes; the ALU is opaque.

Reset
REQ-025 On reset, the FSM SHALL go to IDLE, and gnt0/gnt1, done0/done1 and busy SHALL be 0.
REQ-026 On reset, res, res_flags, alu_a, alu_b and alu_op SHALL be 0, and last-grant SHALL be set so that requester 0 wins the first contention.
REQ-027 Reset mid-transaction SHALL abandon the operation with no done pulse; reset has priority over all transitions.

Configuration
REQ-028 Macro ALU_ARBITER_FIXED_PRIO_EN SHALL select the arbitration policy.
REQ-029 When ALU_ARBITER_FIXED_PRIO_EN is defined, requester 0 SHALL always win contention, and the last-grant register SHALL be absent.
REQ-030 When ALU_ARBITER_FIXED_PRIO_EN is not defined, arbitration SHALL be round-robin per REQ-020.

Verification (bench ALU stub: alu_c = alu_a ^ alu_b, alu_flags = alu_op[4:0])
REQ-031 Single request: req0=1, a0=16'h00FF, b0=16'h0F0F, op0=8'h03 at edge k -> gnt0 cycle k+1, done0 cycle k+3, res=16'h0FF0, res_flags=5'h03, done1/gnt1 never high.
REQ-032 Contention: req0=req1=1 held for 3 transactions -> grants 0,1,0, with done pulses 4 cycles apart; with ALU_ARBITER_FIXED_PRIO_EN defined -> grants 0,0,0.
REQ-033 Operand change after grant: a0 changes to 16'hFFFF the cycle after gnt0 -> res reflects the original a0.
REQ-034 Mid-operation reset: reset=1 in EXEC -> next cycle busy=0 and res=0, no done; the following contention grants requester 0.
REQ-035 Late request: req1 asserted in ISSUE of a requester-0 transaction -> ignored until IDLE, then granted in the next IDLE cycle, with gnt1 exactly 4 cycles after gnt0.
